// File: rtl/hls_kernel_ctrl.sv
// Multi-channel ap_ctrl_hs sequencer: turns software start edges into kernel runs,
// batches or free-runs them, and reports return value, run count, latency and a sticky done.
module hls_kernel_ctrl #(
    parameter int NUM_CH = 2,
    parameter int RET_W  = 32,
    parameter int CNT_W  = 16,
    parameter int CYC_W  = 32
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [NUM_CH-1:0]         sw_start,
    input  logic [NUM_CH-1:0]         sw_stop,
    input  logic [NUM_CH-1:0]         sw_cont,
    input  logic [NUM_CH*CNT_W-1:0]   sw_iters,
    input  logic [NUM_CH-1:0]         sw_irq_en,
    input  logic [NUM_CH-1:0]         sw_done_clr,
    output logic [NUM_CH-1:0]         k_ap_start,
    input  logic [NUM_CH-1:0]         k_ap_done,
    input  logic [NUM_CH-1:0]         k_ap_idle,
    input  logic [NUM_CH-1:0]         k_ap_ready,
    input  logic [NUM_CH*RET_W-1:0]   k_ap_return,
    output logic [NUM_CH-1:0]         st_busy,
    output logic [NUM_CH-1:0]         st_done,
    output logic [NUM_CH*CNT_W-1:0]   st_runs,
    output logic [NUM_CH*CYC_W-1:0]   st_cycles,
    output logic [NUM_CH*RET_W-1:0]   st_return,
    output logic                      irq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1'b1);

    logic irq_r;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        state_t            state_r, state_nx_s;
        logic              start_prev_r, start_rise_s, done_ev_s, last_run_s;
        logic              capture_s, finish_s;
        logic              kstart_r, busy_r, done_r, done_nx_s;
        logic [CNT_W-1:0]  iters_s, rem_r, rem_nx_s, runs_r, runs_nx_s;
        logic [CYC_W-1:0]  cyc_r, cyc_nx_s, cyc_inc_s, cycles_r;
        logic [RET_W-1:0]  ret_r;

        assign iters_s      = sw_iters[ch*CNT_W +: CNT_W];
        assign start_rise_s = sw_start[ch] & ~start_prev_r;
        assign cyc_inc_s    = (cyc_r == {CYC_W{1'b1}}) ? cyc_r : cyc_r + CYC_ONE;
        // A combinational kernel may report ready and done together while still in START.
        assign done_ev_s    = k_ap_done[ch] &
                              ((state_r == S_WAIT) | ((state_r == S_START) & k_ap_ready[ch]));
        assign last_run_s   = sw_stop[ch] | (~sw_cont[ch] & (rem_r == CNT_ONE));

        // Next state, run bookkeeping and sticky-done resolution
        always_comb begin
            state_nx_s = state_r;
            rem_nx_s   = rem_r;
            runs_nx_s  = runs_r;
            cyc_nx_s   = cyc_r;
            capture_s  = 1'b0;
            finish_s   = 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start_rise_s) begin
                        state_nx_s = S_START;
                        rem_nx_s   = (iters_s == {CNT_W{1'b0}}) ? CNT_ONE : iters_s;
                        runs_nx_s  = {CNT_W{1'b0}};
                        cyc_nx_s   = {CYC_W{1'b0}};
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end
                S_START, S_WAIT: begin
                    cyc_nx_s = cyc_inc_s;
                    if (done_ev_s) begin
                        capture_s = 1'b1;
                        runs_nx_s = runs_r + CNT_ONE;
                        rem_nx_s  = sw_cont[ch] ? rem_r : rem_r - CNT_ONE;
                        if (last_run_s) begin
                            state_nx_s = S_IDLE;
                            finish_s   = 1'b1;
                        end else begin
                            state_nx_s = S_START;
                            cyc_nx_s   = {CYC_W{1'b0}};
                        end
                    end else if ((state_r == S_START) && k_ap_ready[ch]) begin
                        state_nx_s = S_WAIT;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                default: begin
                    state_nx_s = S_IDLE;
                end
            endcase
            if (finish_s) begin
                done_nx_s = 1'b1;
            end else if (sw_done_clr[ch]) begin
                done_nx_s = 1'b0;
            end else begin
                done_nx_s = done_r;
            end
        end

        // Channel state and status registers; start history resets high to ignore held levels
        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                state_r      <= S_IDLE;
                start_prev_r <= 1'b1;
                rem_r        <= {CNT_W{1'b0}};
                runs_r       <= {CNT_W{1'b0}};
                cyc_r        <= {CYC_W{1'b0}};
                cycles_r     <= {CYC_W{1'b0}};
                ret_r        <= {RET_W{1'b0}};
                kstart_r     <= 1'b0;
                busy_r       <= 1'b0;
                done_r       <= 1'b0;
            end else begin
                state_r      <= state_nx_s;
                start_prev_r <= sw_start[ch];
                rem_r        <= rem_nx_s;
                runs_r       <= runs_nx_s;
                cyc_r        <= cyc_nx_s;
                kstart_r     <= (state_nx_s == S_START);
                busy_r       <= (state_nx_s != S_IDLE);
                done_r       <= done_nx_s;
                if (capture_s) begin
                    cycles_r <= cyc_inc_s;
                    ret_r    <= k_ap_return[ch*RET_W +: RET_W];
                end
            end
        end

        assign k_ap_start[ch]                 = kstart_r;
        assign st_busy[ch]                    = busy_r;
        assign st_done[ch]                    = done_r;
        assign st_runs[ch*CNT_W +: CNT_W]     = runs_r;
        assign st_cycles[ch*CYC_W +: CYC_W]   = cycles_r;
        assign st_return[ch*RET_W +: RET_W]   = ret_r;
    end

    // Interrupt follows the masked sticky-done vector one cycle later
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(st_done & sw_irq_en);
        end
    end

    assign irq = irq_r;

endmodule

// File: tb/tb_hls_kernel_ctrl.sv
// Directed bench for hls_kernel_ctrl: behavioural kernels drive the DUT, a timestamp-based
// reference model is compared every cycle, and literal expectations pin each scenario.
`timescale 1ns/1ps
module tb_hls_kernel_ctrl;
    localparam int NUM_CH = 2;
    localparam int RET_W  = 32;
    localparam int CNT_W  = 16;
    localparam int CYC_W  = 32;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [1:0]  sw_start = 2'b00, sw_stop = 2'b00, sw_cont = 2'b00;
    logic [1:0]  sw_irq_en = 2'b00, sw_done_clr = 2'b00;
    logic [31:0] sw_iters = 32'd0;
    logic [1:0]  k_ap_start, k_ap_done, k_ap_idle, k_ap_ready;
    logic [63:0] k_ap_return;
    logic [1:0]  st_busy, st_done;
    logic [31:0] st_runs;
    logic [63:0] st_cycles, st_return;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    int rlat[2] = '{1, 1};
    int dlat[2] = '{2, 2};
    int ret_base[2] = '{0, 0};
    int kst_a[2], khigh_a[2], kdn_a[2];

    always #5 ap_clk = ~ap_clk;

    hls_kernel_ctrl #(.NUM_CH(NUM_CH), .RET_W(RET_W), .CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .sw_start(sw_start), .sw_stop(sw_stop), .sw_cont(sw_cont), .sw_iters(sw_iters),
        .sw_irq_en(sw_irq_en), .sw_done_clr(sw_done_clr),
        .k_ap_start(k_ap_start), .k_ap_done(k_ap_done), .k_ap_idle(k_ap_idle),
        .k_ap_ready(k_ap_ready), .k_ap_return(k_ap_return),
        .st_busy(st_busy), .st_done(st_done), .st_runs(st_runs),
        .st_cycles(st_cycles), .st_return(st_return), .irq(irq)
    );

    // Behavioural ap_ctrl_hs kernels: ready at age rlat, done at age dlat after ap_start is seen
    for (genvar g = 0; g < 2; g++) begin : g_k
        logic kbusy = 1'b0;
        int   kt = 0, kstarts = 0, khigh = 0, kdones = 0;
        int   age;
        logic act;
        assign age = kbusy ? kt : 0;
        assign act = kbusy | k_ap_start[g];
        assign k_ap_ready[g] = act && (age == rlat[g]);
        assign k_ap_done[g]  = act && (age == dlat[g]);
        assign k_ap_idle[g]  = ~act;
        assign k_ap_return[g*32 +: 32] = 32'(kdones - ret_base[g]);
        assign kst_a[g]   = kstarts;
        assign khigh_a[g] = khigh;
        assign kdn_a[g]   = kdones;
        always @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                kbusy <= 1'b0;
                kt    <= 0;
            end else begin
                khigh <= khigh + (k_ap_start[g] ? 1 : 0);
                if (act && !kbusy) kstarts <= kstarts + 1;
                if (act) begin
                    if (k_ap_done[g]) begin
                        kbusy  <= 1'b0;
                        kdones <= kdones + 1;
                    end else begin
                        kbusy <= 1'b1;
                        kt    <= age + 1;
                    end
                end
            end
        end
    end

    // Reference model: runs are tracked by start timestamps rather than controller states
    logic [1:0]  m_busy, m_kstart, m_done, m_prev;
    logic        m_irq;
    logic [31:0] m_runs;
    logic [63:0] m_cycles, m_ret;
    int          m_rem[2], m_t0[2];
    int          cyc = 0;

    always @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            m_busy <= 2'b00; m_kstart <= 2'b00; m_done <= 2'b00; m_prev <= 2'b11;
            m_irq <= 1'b0; m_runs <= 32'd0; m_cycles <= 64'd0; m_ret <= 64'd0;
        end else begin
            cyc    <= cyc + 1;
            m_prev <= sw_start;
            m_irq  <= |(m_done & sw_irq_en);
            for (int c = 0; c < 2; c++) begin
                if (!m_busy[c]) begin
                    if (sw_start[c] && !m_prev[c]) begin
                        m_busy[c]   <= 1'b1;
                        m_kstart[c] <= 1'b1;
                        m_runs[c*16 +: 16] <= 16'd0;
                        m_t0[c]  <= cyc + 1;
                        m_rem[c] <= (sw_iters[c*16 +: 16] == 16'd0) ? 1 : int'(sw_iters[c*16 +: 16]);
                    end
                    if (sw_done_clr[c]) m_done[c] <= 1'b0;
                end else if (k_ap_done[c] && (!m_kstart[c] || k_ap_ready[c])) begin
                    m_runs[c*16 +: 16]   <= m_runs[c*16 +: 16] + 16'd1;
                    m_ret[c*32 +: 32]    <= k_ap_return[c*32 +: 32];
                    m_cycles[c*32 +: 32] <= 32'(cyc - m_t0[c] + 1);
                    if (!sw_cont[c]) m_rem[c] <= m_rem[c] - 1;
                    if (sw_stop[c] || (!sw_cont[c] && m_rem[c] == 1)) begin
                        m_busy[c]   <= 1'b0;
                        m_kstart[c] <= 1'b0;
                        m_done[c]   <= 1'b1;
                    end else begin
                        m_kstart[c] <= 1'b1;
                        m_t0[c]     <= cyc + 1;
                        if (sw_done_clr[c]) m_done[c] <= 1'b0;
                    end
                end else begin
                    if (m_kstart[c] && k_ap_ready[c]) m_kstart[c] <= 1'b0;
                    if (sw_done_clr[c]) m_done[c] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, sampled just after the active edge
    always @(posedge ap_clk) begin
        #1;
        chk("k_ap_start", 64'(k_ap_start), 64'(m_kstart));
        chk("st_busy",    64'(st_busy),    64'(m_busy));
        chk("st_done",    64'(st_done),    64'(m_done));
        chk("st_runs",    64'(st_runs),    64'(m_runs));
        chk("st_cycles",  st_cycles,       m_cycles);
        chk("st_return",  st_return,       m_ret);
        chk("irq",        64'(irq),        64'(m_irq));
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(negedge ap_clk);
        sw_start = sw_start | m;
        @(negedge ap_clk);
        sw_start = sw_start & ~m;
    endtask

    task automatic pulse_clr(input logic [1:0] m);
        @(negedge ap_clk);
        sw_done_clr = m;
        @(negedge ap_clk);
        sw_done_clr = 2'b00;
    endtask

    task automatic wait_idle(input logic [1:0] m, input string nm);
        int n;
        n = 0;
        while (((st_busy & m) != 2'b00) && n < 400) begin
            tick();
            n++;
        end
        chk(nm, 64'((st_busy & m) != 2'b00), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, h0;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        chk("rst_start", 64'(k_ap_start), 64'd0);
        chk("rst_busy",  64'(st_busy),    64'd0);
        chk("rst_done",  64'(st_done),    64'd0);
        chk("rst_irq",   64'(irq),        64'd0);

        // Single run: ready@+3, done@+10
        rlat[0] = 3; dlat[0] = 10; sw_iters = {16'd0, 16'd1}; sw_irq_en = 2'b01;
        h0 = khigh_a[0]; s0 = kst_a[0];
        pulse_start(2'b01);
        wait_idle(2'b01, "t1_idle_timeout");
        chk("t1_done",     64'(st_done[0]),      64'd1);
        chk("t1_irq_pre",  64'(irq),             64'd0);
        chk("t1_cycles",   64'(st_cycles[31:0]), 64'd11);
        chk("t1_runs",     64'(st_runs[15:0]),   64'd1);
        chk("t1_start_hi", 64'(khigh_a[0] - h0), 64'd4);
        chk("t1_starts",   64'(kst_a[0] - s0),   64'd1);
        tick();
        chk("t1_irq", 64'(irq), 64'd1);

        // Batch of 3, return = run index
        rlat[0] = 2; dlat[0] = 4; sw_iters = {16'd0, 16'd3}; ret_base[0] = kdn_a[0];
        pulse_clr(2'b01);
        chk("t2_clr", 64'(st_done[0]), 64'd0);
        s0 = kst_a[0];
        pulse_start(2'b01);
        wait_idle(2'b01, "t2_idle_timeout");
        chk("t2_runs",   64'(st_runs[15:0]),   64'd3);
        chk("t2_ret",    64'(st_return[31:0]), 64'd2);
        chk("t2_starts", 64'(kst_a[0] - s0),   64'd3);
        chk("t2_done",   64'(st_done[0]),      64'd1);

        // Continuous mode, stop during run 5
        rlat[0] = 1; dlat[0] = 3; sw_iters = {16'd0, 16'd2}; sw_cont = 2'b01; ret_base[0] = kdn_a[0];
        s0 = kst_a[0];
        pulse_start(2'b01);
        begin
            int n;
            n = 0;
            while ((kst_a[0] - s0) < 5 && n < 200) begin
                tick();
                n++;
            end
        end
        chk("t3_reach5", 64'(kst_a[0] - s0), 64'd5);
        @(negedge ap_clk);
        sw_stop[0] = 1'b1;
        wait_idle(2'b01, "t3_idle_timeout");
        @(negedge ap_clk);
        sw_stop = 2'b00; sw_cont = 2'b00;
        chk("t3_runs", 64'(st_runs[15:0]),   64'd5);
        chk("t3_ret",  64'(st_return[31:0]), 64'd4);
        chk("t3_busy", 64'(st_busy[0]),      64'd0);
        repeat (10) tick();
        chk("t3_no6th", 64'(kst_a[0] - s0), 64'd5);

        // Coincident ready+done, clear on the set cycle
        rlat[0] = 0; dlat[0] = 0; sw_iters = {16'd0, 16'd1};
        pulse_clr(2'b01);
        chk("t4_clr", 64'(st_done[0]), 64'd0);
        s0 = kst_a[0];
        @(negedge ap_clk);
        sw_start[0] = 1'b1;
        @(negedge ap_clk);
        sw_start[0] = 1'b0;
        sw_done_clr[0] = 1'b1;
        @(negedge ap_clk);
        sw_done_clr = 2'b00;
        chk("t4_done",   64'(st_done[0]),      64'd1);
        chk("t4_runs",   64'(st_runs[15:0]),   64'd1);
        chk("t4_cycles", 64'(st_cycles[31:0]), 64'd1);
        chk("t4_busy",   64'(st_busy[0]),      64'd0);
        chk("t4_starts", 64'(kst_a[0] - s0),   64'd1);

        // Independent channels started together; ch1 requests 0 iterations
        rlat[0] = 1; dlat[0] = 5; rlat[1] = 2; dlat[1] = 12;
        sw_iters = {16'd0, 16'd1}; sw_irq_en = 2'b10;
        pulse_clr(2'b11);
        s1 = kst_a[1];
        pulse_start(2'b11);
        wait_idle(2'b01, "t5_ch0_timeout");
        chk("t5_cyc0",  64'(st_cycles[31:0]), 64'd6);
        chk("t5_irq0",  64'(irq),             64'd0);
        chk("t5_busy1", 64'(st_busy[1]),      64'd1);
        wait_idle(2'b10, "t5_ch1_timeout");
        chk("t5_cyc1",    64'(st_cycles[63:32]), 64'd13);
        chk("t5_runs1",   64'(st_runs[31:16]),   64'd1);
        chk("t5_done",    64'(st_done),          64'd3);
        chk("t5_starts1", 64'(kst_a[1] - s1),    64'd1);
        tick();
        chk("t5_irq1", 64'(irq), 64'd1);

        // Reset while waiting for done, start level held through release
        rlat[0] = 2; dlat[0] = 30; sw_iters = {16'd0, 16'd1};
        @(negedge ap_clk);
        sw_start[0] = 1'b1;
        repeat (8) tick();
        chk("t6_busy_pre", 64'(st_busy[0]), 64'd1);
        #2;
        ap_rst = 1'b1;
        #1;
        chk("t6_async_start",  64'(k_ap_start), 64'd0);
        chk("t6_async_busy",   64'(st_busy),    64'd0);
        chk("t6_async_done",   64'(st_done),    64'd0);
        chk("t6_async_runs",   64'(st_runs),    64'd0);
        chk("t6_async_cycles", st_cycles,       64'd0);
        chk("t6_async_ret",    st_return,       64'd0);
        chk("t6_async_irq",    64'(irq),        64'd0);
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        s0 = kst_a[0];
        repeat (10) tick();
        chk("t6_held_busy",   64'(st_busy[0]),    64'd0);
        chk("t6_held_starts", 64'(kst_a[0] - s0), 64'd0);
        @(negedge ap_clk);
        sw_start[0] = 1'b0;
        pulse_start(2'b01);
        wait_idle(2'b01, "t6_idle_timeout");
        chk("t6_runs",   64'(st_runs[15:0]),   64'd1);
        chk("t6_cycles", 64'(st_cycles[31:0]), 64'd31);
        chk("t6_starts", 64'(kst_a[0] - s0),   64'd1);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
